// File: rtl/cordic_req_sequencer_if.sv
// Bundle of the request, calc_cordic and response handshakes around the sequencer.
// The slave view is the sequencer; the master view is the surrounding environment.
interface cordic_req_sequencer_if #(
    parameter int WIDTH = 32
);
    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              in_op;
    logic signed [WIDTH-1:0] in_x;
    logic signed [WIDTH-1:0] in_y;
    logic signed [WIDTH-1:0] in_z;

    logic                    cordic_en;
    logic [2:0]              cordic_op;
    logic signed [WIDTH-1:0] cordic_x;
    logic signed [WIDTH-1:0] cordic_y;
    logic signed [WIDTH-1:0] cordic_z;
    logic signed [WIDTH-1:0] cordic_result;
    logic                    cordic_done;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH-1:0] out_result;
    logic                    out_error;

    modport slave (
        input  in_valid, in_op, in_x, in_y, in_z,
        output in_ready,
        output cordic_en, cordic_op, cordic_x, cordic_y, cordic_z,
        input  cordic_result, cordic_done,
        output out_valid, out_result, out_error,
        input  out_ready
    );

    modport master (
        output in_valid, in_op, in_x, in_y, in_z,
        input  in_ready,
        input  cordic_en, cordic_op, cordic_x, cordic_y, cordic_z,
        output cordic_result, cordic_done,
        input  out_valid, out_result, out_error,
        output out_ready
    );
endinterface

// File: rtl/cordic_req_sequencer.sv
// Request front-end / result back-end for calc_cordic: angle range reduction and
// quadrant folding for SIN/COS, timeout supervision and response handshake.
module cordic_req_sequencer #(
    parameter int WIDTH     = 32,
    parameter int TIMEOUT   = 64,
    parameter int PI_Q      = 205887,
    parameter int HALF_PI_Q = 102944,
    parameter int TWO_PI_Q  = 411775
) (
    input  logic                   clk,
    input  logic                   rst,
    cordic_req_sequencer_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic signed [WIDTH-1:0] PI_S       = WIDTH'(PI_Q);
    localparam logic signed [WIDTH-1:0] NEG_PI_S   = -WIDTH'(PI_Q);
    localparam logic signed [WIDTH-1:0] HALF_PI_S  = WIDTH'(HALF_PI_Q);
    localparam logic signed [WIDTH-1:0] NEG_HALF_S = -WIDTH'(HALF_PI_Q);
    localparam logic signed [WIDTH-1:0] TWO_PI_S   = WIDTH'(TWO_PI_Q);
    localparam logic signed [WIDTH-1:0] MIN_S      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MAX_S      = {1'b0, {(WIDTH-1){1'b1}}};

    localparam logic [2:0] OP_SIN  = 3'd0;
    localparam logic [2:0] OP_COS  = 3'd1;
    localparam logic [2:0] OP_LAST = 3'd5;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REDUCE,
        FOLD,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t                  state;
    logic [2:0]              op_q;
    logic signed [WIDTH-1:0] x_q;
    logic signed [WIDTH-1:0] y_q;
    logic signed [WIDTH-1:0] z_q;
    logic                    negate;
    logic [CNT_W-1:0]        wait_cnt;

    // The most negative value has no positive counterpart, so it clips to the maximum.
    function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
        return (v == MIN_S) ? MAX_S : -v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= '0;
            x_q            <= '0;
            y_q            <= '0;
            z_q            <= '0;
            negate         <= 1'b0;
            wait_cnt       <= '0;
            bus.in_ready   <= 1'b0;
            bus.cordic_en  <= 1'b0;
            bus.cordic_op  <= '0;
            bus.cordic_x   <= '0;
            bus.cordic_y   <= '0;
            bus.cordic_z   <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_result <= '0;
            bus.out_error  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.in_ready <= 1'b0;
                        op_q         <= bus.in_op;
                        x_q          <= bus.in_x;
                        y_q          <= bus.in_y;
                        z_q          <= bus.in_z;
                        negate       <= 1'b0;
                        if (bus.in_op > OP_LAST) begin
                            bus.out_valid  <= 1'b1;
                            bus.out_error  <= 1'b1;
                            bus.out_result <= '0;
                            state          <= RESP;
                        end else if (bus.in_op == OP_SIN || bus.in_op == OP_COS) begin
                            state <= REDUCE;
                        end else begin
                            state <= ISSUE;
                        end
                    end else begin
                        bus.in_ready <= 1'b1;
                    end
                end

                // Bring the angle into [-pi, +pi] one 2*pi step per cycle.
                REDUCE: begin
                    if (z_q > PI_S) begin
                        z_q <= z_q - TWO_PI_S;
                    end else if (z_q < NEG_PI_S) begin
                        z_q <= z_q + TWO_PI_S;
                    end else begin
                        state <= FOLD;
                    end
                end

                // Reflect outer quadrants onto [-pi/2, pi/2]; sin is symmetric there, cos flips sign.
                FOLD: begin
                    if (z_q > HALF_PI_S) begin
                        z_q    <= PI_S - z_q;
                        negate <= (op_q == OP_COS);
                    end else if (z_q < NEG_HALF_S) begin
                        z_q    <= NEG_PI_S - z_q;
                        negate <= (op_q == OP_COS);
                    end
                    state <= ISSUE;
                end

                ISSUE: begin
                    bus.cordic_op <= op_q;
                    bus.cordic_x  <= x_q;
                    bus.cordic_y  <= y_q;
                    bus.cordic_z  <= z_q;
                    bus.cordic_en <= 1'b1;
                    wait_cnt      <= '0;
                    state         <= WAIT;
                end

                // A done arriving on the final counted cycle still takes priority.
                WAIT: begin
                    if (bus.cordic_done) begin
                        bus.cordic_en  <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.out_error  <= 1'b0;
                        bus.out_result <= negate ? sat_neg(bus.cordic_result) : bus.cordic_result;
                        state          <= RESP;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus.cordic_en  <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        bus.out_error  <= 1'b1;
                        bus.out_result <= '0;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    if (bus.out_valid && bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_req_sequencer.sv
// Directed bench for cordic_req_sequencer; the bench itself plays calc_cordic
// and returns hand-computed results.
module tb_cordic_req_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   en_cycles    = 0;
    int   cnt;

    cordic_req_sequencer_if #(.WIDTH(32)) bus ();

    cordic_req_sequencer #(
        .WIDTH    (32),
        .TIMEOUT  (8),
        .PI_Q     (205887),
        .HALF_PI_Q(102944),
        .TWO_PI_Q (411775)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cordic_en === 1'b1) en_cycles++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(observed), observed, $signed(expected), expected);
        end
    endtask

    // Present one request and return at the negedge after it was accepted.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] z);
        int n;
        bus.in_op    = op;
        bus.in_x     = x;
        bus.in_y     = y;
        bus.in_z     = z;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
    endtask

    // Act as calc_cordic: check the issued operands, hold for wait_cycles, then pulse done.
    task automatic serveCordic(input string tag, input logic [2:0] op, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] z,
                               input int wait_cycles, input logic [31:0] result);
        int n;
        n = 0;
        while (bus.cordic_en !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_en"}, {31'b0, bus.cordic_en}, 32'd1);
        checkOutput({tag, "_op"}, {29'b0, bus.cordic_op}, {29'b0, op});
        checkOutput({tag, "_x"}, bus.cordic_x, x);
        checkOutput({tag, "_y"}, bus.cordic_y, y);
        checkOutput({tag, "_z"}, bus.cordic_z, z);
        repeat (wait_cycles) begin
            @(negedge clk);
            checkOutput({tag, "_en_held"}, {31'b0, bus.cordic_en}, 32'd1);
        end
        bus.cordic_result = result;
        bus.cordic_done   = 1'b1;
        @(negedge clk);
        bus.cordic_done   = 1'b0;
        bus.cordic_result = 32'hDEAD_BEEF;
        checkOutput({tag, "_en_drop"}, {31'b0, bus.cordic_en}, 32'd0);
    endtask

    // Wait for the response, optionally stall out_ready, then complete the handshake.
    task automatic collectResponse(input string tag, input logic [31:0] result, input logic err,
                                   input int stall_cycles);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        checkOutput({tag, "_result"}, bus.out_result, result);
        checkOutput({tag, "_error"}, {31'b0, bus.out_error}, {31'b0, err});
        repeat (stall_cycles) begin
            @(negedge clk);
            checkOutput({tag, "_stall_valid"}, {31'b0, bus.out_valid}, 32'd1);
            checkOutput({tag, "_stall_result"}, bus.out_result, result);
            checkOutput({tag, "_stall_in_ready"}, {31'b0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.in_op         = '0;
        bus.in_x          = '0;
        bus.in_y          = '0;
        bus.in_z          = '0;
        bus.cordic_result = '0;
        bus.cordic_done   = 1'b0;
        bus.out_ready     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("rst_cordic_en", {31'b0, bus.cordic_en}, 32'd0);
        checkOutput("rst_cordic_z", bus.cordic_z, 32'd0);
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_result", bus.out_result, 32'd0);
        checkOutput("rst_out_error", {31'b0, bus.out_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // COS(pi): folds to 0 and negates the model's 1.0
        applyStimulus(3'd1, 32'd39797, 32'd0, 32'd205887);
        serveCordic("cos_pi", 3'd1, 32'd39797, 32'd0, 32'd0, 2, 32'd65536);
        collectResponse("cos_pi", -32'sd65536, 1'b0, 0);

        // SIN(3pi/4): folds to pi/4, no negation
        applyStimulus(3'd0, 32'd39797, 32'd0, 32'd154416);
        serveCordic("sin_3pi4", 3'd0, 32'd39797, 32'd0, 32'd51471, 1, 32'd46341);
        collectResponse("sin_3pi4", 32'd46341, 1'b0, 0);

        // SIN(7 rad): one reduction step, enable held for 5 extra cycles
        applyStimulus(3'd0, 32'd39797, 32'd0, 32'd458752);
        serveCordic("sin_7", 3'd0, 32'd39797, 32'd0, 32'd46977, 5, 32'd30000);
        collectResponse("sin_7", 32'd30000, 1'b0, 0);

        // SIN(-7 rad): reduction from below
        applyStimulus(3'd0, 32'd39797, 32'd0, -32'sd458752);
        serveCordic("sin_m7", 3'd0, 32'd39797, 32'd0, -32'sd46977, 0, -32'sd30000);
        collectResponse("sin_m7", -32'sd30000, 1'b0, 0);

        // COS(-3pi/4): negative fold with negation
        applyStimulus(3'd1, 32'd39797, 32'd0, -32'sd154416);
        serveCordic("cos_m3pi4", 3'd1, 32'd39797, 32'd0, -32'sd51471, 0, 32'd46341);
        collectResponse("cos_m3pi4", -32'sd46341, 1'b0, 0);

        // COS(pi/2) exactly: not folded, not negated
        applyStimulus(3'd1, 32'd39797, 32'd0, 32'd102944);
        serveCordic("cos_half", 3'd1, 32'd39797, 32'd0, 32'd102944, 0, 32'd5);
        collectResponse("cos_half", 32'd5, 1'b0, 0);

        // COS of a large angle: three reduction steps
        applyStimulus(3'd1, 32'd39797, 32'd0, 32'd1300000);
        serveCordic("cos_big", 3'd1, 32'd39797, 32'd0, 32'd64675, 0, 32'd1000);
        collectResponse("cos_big", 32'd1000, 1'b0, 0);

        // Negating the most negative value saturates
        applyStimulus(3'd1, 32'd39797, 32'd0, 32'd205887);
        serveCordic("cos_sat", 3'd1, 32'd39797, 32'd0, 32'd0, 0, 32'h8000_0000);
        collectResponse("cos_sat", 32'h7FFF_FFFF, 1'b0, 0);

        // Illegal op: error response, enable never raised
        en_cycles = 0;
        applyStimulus(3'd6, 32'd1, 32'd2, 32'd3);
        collectResponse("illegal", 32'd0, 1'b1, 0);
        checkOutput("illegal_no_en", en_cycles, 32'd0);

        // Timeout: enable high for exactly 8 WAIT cycles, then error
        applyStimulus(3'd2, 32'd5, 32'd6, 32'd7);
        cnt = 0;
        while (bus.cordic_en !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("tmo_en_rise", {31'b0, bus.cordic_en}, 32'd1);
        cnt = 0;
        while (bus.cordic_en === 1'b1 && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checkOutput("tmo_en_cycles", cnt, 32'd8);
        collectResponse("tmo", 32'd0, 1'b1, 0);

        // Done on the final counted cycle wins over the timeout
        applyStimulus(3'd3, 32'd11, 32'd12, 32'd13);
        serveCordic("tmo_tie", 3'd3, 32'd11, 32'd12, 32'd13, 7, 32'd1234);
        collectResponse("tmo_tie", 32'd1234, 1'b0, 0);

        // MULT pass-through with a 5-cycle response stall
        applyStimulus(3'd2, 32'd131072, 32'd0, 32'd196608);
        serveCordic("mult", 3'd2, 32'd131072, 32'd0, 32'd196608, 2, 32'd393216);
        collectResponse("mult", 32'd393216, 1'b0, 5);

        // Reset pulsed mid-WAIT aborts without a response
        applyStimulus(3'd0, 32'd39797, 32'd0, 32'd0);
        cnt = 0;
        while (bus.cordic_en !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("abort_en_rise", {31'b0, bus.cordic_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_en_drop", {31'b0, bus.cordic_en}, 32'd0);
        checkOutput("abort_no_valid", {31'b0, bus.out_valid}, 32'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("abort_still_no_valid", {31'b0, bus.out_valid}, 32'd0);
        end
        checkOutput("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
